// File: rtl/aes_inv_cipher.sv
// Iterative AES inverse cipher: one round per clock, NR+1 cycles per block.
// The expanded key schedule is read combinationally and must be held stable by the source.
module aes_inv_cipher #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [127:0]          data_in,
    input  logic [128*(NR+1)-1:0] round_keys,
    output logic                  busy,
    output logic                  done,
    output logic [127:0]          data_out
);

    localparam logic [3:0] RC_INIT = 4'(NR - 1);

    // FIPS-197 inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    if ((NK != 4 && NK != 6 && NK != 8) || (NR != NK + 6)) begin : g_bad_params
        $error("aes_inv_cipher: NR must equal NK+6 with NK in {4,6,8}");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_LAST
    } state_e;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Byte (row r, column c) lives at index 4*c+r; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
        end
        return o;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] blk_q, blk_d;
    logic [3:0]   rc_q, rc_d;
    logic [127:0] dout_q, dout_d;
    logic         done_q, done_d;

    logic [127:0] rk_sel;
    logic [127:0] sub_shift;
    logic [127:0] round_out;
    logic [127:0] last_out;
    logic [127:0] load_val;

    // Mux over legal round indices only, so rc can never address past round NR.
    always_comb begin
        rk_sel = '0;
        for (int r = 0; r <= NR; r++) begin
            if (rc_q == 4'(r)) begin
                rk_sel = round_keys[128*r +: 128];
            end
        end
    end

    always_comb begin
        sub_shift = inv_sub_bytes(inv_shift_rows(blk_q));
        round_out = inv_mix_columns(sub_shift ^ rk_sel);
        last_out  = sub_shift ^ round_keys[127:0];
        load_val  = data_in ^ round_keys[128*NR +: 128];
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        rc_d    = rc_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    blk_d   = load_val;
                    rc_d    = RC_INIT;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                blk_d = round_out;
                rc_d  = rc_q - 4'd1;
                if (rc_q == 4'd1) begin
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                dout_d  = last_out;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            blk_q   <= '0;
            rc_q    <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            rc_q    <= rc_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Bench for aes_inv_cipher: FIPS-197 vectors on NR=10 and NR=14 instances,
// with a scoreboard queue checked on every done pulse of the NR=10 instance.
module tb_aes_inv_cipher;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C3_KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT    = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [127:0]  data_in;
    logic [1407:0] rk10;
    logic          busy;
    logic          done;
    logic [127:0]  data_out;

    logic          start14;
    logic [127:0]  data_in14;
    logic [1919:0] rk14;
    logic          busy14;
    logic          done14;
    logic [127:0]  dout14;

    logic [1407:0] rk_fips;
    logic [1407:0] rk_c1;
    logic [1919:0] rk_tmp;

    logic [7:0]    sbox_tab [256];
    logic [127:0]  exp_q [$];
    logic [127:0]  sb_exp;
    int            total;
    int            bad;
    int            done_cnt;

    aes_inv_cipher #(.NR(10), .NK(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_in    (data_in),
        .round_keys (rk10),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out)
    );

    aes_inv_cipher #(.NR(14), .NK(8)) dut14 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start14),
        .data_in    (data_in14),
        .round_keys (rk14),
        .busy       (busy14),
        .done       (done14),
        .data_out   (dout14)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference key schedule ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr,
                              output logic [1919:0] rk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        rk   = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_done: data_out=%h required=no done pulse", data_out);
            end else begin
                sb_exp = exp_q.pop_front();
                if (data_out !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_data_out: got=%h required=%h", data_out, sb_exp);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_block(input logic [127:0] ct, input logic [127:0] pt, output int cycles,
                            output logic busy_mid, output logic busy_end,
                            output logic [127:0] dout_mid);
        @(negedge clk);
        data_in  = ct;
        start    = 1'b1;
        exp_q.push_back(pt);
        cycles   = 0;
        busy_mid = 1'b0;
        dout_mid = '0;
        while (cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = 1'b0;
            if (cycles == 5) begin
                busy_mid = busy;
                dout_mid = data_out;
            end
            if (done) break;
        end
        busy_end = busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        total += 6;
        if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got=%b required=0", busy); end
        if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got=%b required=0", done); end
        if (data_out !== '0)   begin bad++; $display("FAIL reset_data_out: got=%h required=0", data_out); end
        if (busy14 !== 1'b0)   begin bad++; $display("FAIL reset_busy14: got=%b required=0", busy14); end
        if (done14 !== 1'b0)   begin bad++; $display("FAIL reset_done14: got=%b required=0", done14); end
        if (dout14 !== '0)     begin bad++; $display("FAIL reset_dout14: got=%h required=0", dout14); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset_busy: got=%b required=0", busy); end
    endtask

    task automatic test_fips();
        int cycles;
        logic bm, be;
        logic [127:0] dm;
        do_block(FIPS_CT, FIPS_PT, cycles, bm, be, dm);
        total += 4;
        if (cycles !== 11) begin bad++; $display("FAIL fips_latency: got=%0d required=11", cycles); end
        if (bm !== 1'b1)   begin bad++; $display("FAIL fips_busy_mid: got=%b required=1", bm); end
        if (be !== 1'b0)   begin bad++; $display("FAIL fips_busy_at_done: got=%b required=0", be); end
        if (dm !== '0)     begin bad++; $display("FAIL fips_dout_hold: got=%h required=0", dm); end
    endtask

    task automatic test_c1();
        int cycles;
        logic bm, be;
        logic [127:0] dm;
        rk10 = rk_c1;
        do_block(C1_CT, C_PT, cycles, bm, be, dm);
        total += 4;
        if (cycles !== 11)  begin bad++; $display("FAIL c1_latency: got=%0d required=11", cycles); end
        if (bm !== 1'b1)    begin bad++; $display("FAIL c1_busy_mid: got=%b required=1", bm); end
        if (be !== 1'b0)    begin bad++; $display("FAIL c1_busy_at_done: got=%b required=0", be); end
        if (dm !== FIPS_PT) begin bad++; $display("FAIL c1_dout_hold: got=%h required=%h", dm, FIPS_PT); end
    endtask

    task automatic test_nr14();
        int cycles;
        @(negedge clk);
        data_in14 = C3_CT;
        start14   = 1'b1;
        cycles    = 0;
        while (cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start14 = 1'b0;
            if (done14) break;
        end
        total += 3;
        if (cycles !== 15)   begin bad++; $display("FAIL nr14_latency: got=%0d required=15", cycles); end
        if (dout14 !== C_PT) begin bad++; $display("FAIL nr14_data_out: got=%h required=%h", dout14, C_PT); end
        if (busy14 !== 1'b0) begin bad++; $display("FAIL nr14_busy_at_done: got=%b required=0", busy14); end
    endtask

    task automatic test_start_ignored();
        int base;
        rk10 = rk_fips;
        base = done_cnt;
        @(negedge clk);
        data_in = FIPS_CT;
        start   = 1'b1;
        exp_q.push_back(FIPS_PT);
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (c == 5) begin
                data_in = {$urandom, $urandom, $urandom, $urandom};
                start   = 1'b1;
            end
        end
        total += 3;
        if (done_cnt - base !== 1) begin bad++; $display("FAIL ignored_done_count: got=%0d required=1", done_cnt - base); end
        if (data_out !== FIPS_PT)  begin bad++; $display("FAIL ignored_data_out: got=%h required=%h", data_out, FIPS_PT); end
        if (busy !== 1'b0)         begin bad++; $display("FAIL ignored_busy: got=%b required=0", busy); end
    endtask

    task automatic test_back_to_back();
        int n;
        rk10 = rk_c1;
        @(negedge clk);
        data_in = C1_CT;
        start   = 1'b1;
        exp_q.push_back(C_PT);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (n < 40) begin
                @(posedge clk);
                n++;
                @(negedge clk);
                if (done) break;
            end
            total++;
            if (n !== 11) begin bad++; $display("FAIL b2b_interval_%0d: got=%0d required=11", k, n); end
            if (k < 2) exp_q.push_back(C_PT);
            else start = 1'b0;
        end
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop_busy: got=%b required=0", busy); end
    endtask

    task automatic test_reset_mid();
        int base;
        int cycles;
        logic bm, be;
        logic [127:0] dm;
        rk10 = rk_fips;
        @(negedge clk);
        data_in = FIPS_CT;
        start   = 1'b1;
        exp_q.push_back(FIPS_PT);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got=%b required=1", busy); end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        base = done_cnt;
        total += 3;
        if (busy !== 1'b0)   begin bad++; $display("FAIL rstmid_busy: got=%b required=0", busy); end
        if (done !== 1'b0)   begin bad++; $display("FAIL rstmid_done: got=%b required=0", done); end
        if (data_out !== '0) begin bad++; $display("FAIL rstmid_data_out: got=%h required=0", data_out); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        total += 2;
        if (done_cnt !== base) begin bad++; $display("FAIL rstmid_no_done: got=%0d required=%0d", done_cnt, base); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL rstmid_idle: got=%b required=0", busy); end
        do_block(FIPS_CT, FIPS_PT, cycles, bm, be, dm);
        total++;
        if (cycles !== 11) begin bad++; $display("FAIL rstmid_relaunch_latency: got=%0d required=11", cycles); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total     = 0;
        bad       = 0;
        done_cnt  = 0;
        rst_n     = 1'b1;
        start     = 1'b0;
        start14   = 1'b0;
        data_in   = '0;
        data_in14 = '0;
        build_sbox();
        expand_key({FIPS_KEY, 128'h0}, 4, 10, rk_tmp);
        rk_fips = rk_tmp[1407:0];
        expand_key({C1_KEY, 128'h0}, 4, 10, rk_tmp);
        rk_c1 = rk_tmp[1407:0];
        expand_key(C3_KEY, 8, 14, rk_tmp);
        rk14 = rk_tmp;
        rk10 = rk_fips;

        test_reset();
        test_fips();
        test_c1();
        test_nr14();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();

        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got=%0d pending required=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
